spi_cmd_scheduler: RTL and testbench
====================================

SPI_CMD_SCHEDULER -- requirements
Module: spi_cmd_scheduler

Interface
REQ-001 SHALL have parameter CS_GAP, default 2: minimum clk cycles chip_select stays high between transactions (legal range 1..15).
REQ-002 SHALL have port clk, input, 1: system clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port req, input, 2: per-requester transaction request, level, bit k = requester k.
REQ-005 SHALL have port op, input, 16: opcode, op[8k+7:8k] for requester k.
REQ-006 SHALL have port addr, input, 48: 24-bit flash address, addr[24k+23:24k] for requester k.
REQ-007 SHALL have port has_addr, input, 2: bit k set = requester k's transaction includes an address phase.
REQ-008 SHALL have port nbytes, input, 6: read byte count, nbytes[3k+2:3k] for requester k.
REQ-009 SHALL have port gnt, output, 2: one-hot grant, high for the whole transaction.
REQ-010 SHALL have port done, output, 2: one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rdata, output, 32: read data, valid in the done cycle, held until the next grant.
REQ-012 SHALL have port busy, output, 1: high from the grant until the gap phase ends.
REQ-013 SHALL have ports SPICLK output 1, SPIMOSI output 1, SPIMISO input 1, chip_select output 1 (active-low): SPI mode 0 pins.

Function
REQ-014 SHALL implement states IDLE, CS_SETUP, OPCODE, ADDR, DATA, GAP.
REQ-015 Transitions SHALL be:
- IDLE -> CS_SETUP when any req is high; the gnt bit rises in the same edge.
- CS_SETUP (1 cycle) -> OPCODE.
- OPCODE (16 cycles) -> ADDR if has_addr, else DATA.
- ADDR (48 cycles) -> DATA.
- DATA (16 x effective count cycles; 0 cycles when the count is 0) -> GAP.
- GAP (CS_GAP cycles) -> IDLE.
REQ-016 At grant, op, addr, has_addr and nbytes SHALL be latched for the granted requester; later input changes SHALL be ignored.
REQ-017 chip_select SHALL be low in CS_SETUP, OPCODE, ADDR and DATA, and high otherwise.
REQ-018 Clocking and bit timing SHALL be:
- SPICLK toggles every clk cycle in OPCODE, ADDR and DATA, and is otherwise low; one bit = 2 clk cycles.
- Data is shifted MSB first.
- SPIMOSI is updated when SPICLK falls (first bit valid at CS_SETUP); SPIMOSI = 0 during DATA.
- SPIMISO is sampled on the clk edge at which SPICLK rises.
REQ-019 Byte count handling SHALL be:
- nbytes = 0 gives a command-only transaction (no DATA phase).
- Values 5..7 are clamped to 4.
REQ-020 Received bytes SHALL be right-aligned in rdata, with unused upper bytes zero.
REQ-021 At DATA (or ADDR/OPCODE if last phase) exit, done[k] SHALL pulse exactly 1 cycle, coincident with chip_select rising and gnt falling.
REQ-022 When both req bits are high in IDLE, round-robin SHALL grant the requester not granted last; after reset the pointer favours requester 0.
REQ-023 req asserted while busy SHALL wait and is never lost; a req dropped before grant SHALL produce no transaction.
REQ-024 Total latency from req sampled in IDLE to done SHALL be 1 + 16 + 48·has_addr + 16·count cycles.

Reset
REQ-025 During reset and after it, outputs SHALL be as follows:
- gnt = 0, done = 0, rdata = 0, busy = 0.
- SPICLK = 0, SPIMOSI = 0, chip_select = 1.
- State = IDLE, RR pointer = requester 0.
REQ-026 Reset mid-transaction SHALL abort immediately: chip_select high, no done pulse, the request is not remembered.

Configuration
REQ-027 With SPI_SCHED_FIXED_PRIO_EN defined, requester 0 SHALL always win simultaneous requests; without it, REQ-022 round-robin SHALL apply.

Structure
REQ-028 Package spi_pkg SHALL hold the state encoding and opcode constants RDID 8'h9F, READ 8'h03, RDSR 8'h05, WREN 8'h06.
REQ-029 Arbitration SHALL be a sub-module spi_rr_arbiter (req[1:0], enable, gnt one-hot, pointer update on accept); sequencing and shifting stay in spi_cmd_scheduler.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- V1: req0, op 9F, has_addr 0, nbytes 3, slave returns EF 40 18 -> 64 SPICLK edges total, done[0] at cycle 65, rdata = 32'h00EF4018.
- V2: req1, op 03, addr 24'h012345, nbytes 4, slave returns AA BB CC DD -> MOSI shows 03 01 23 45, done[1] at cycle 129, rdata = 32'hAABBCCDD.
- V3: req = 2'b11 held, both op 05, nbytes 1 -> grants alternate 0,1,0; chip_select high for ≥ CS_GAP = 2 cycles between transactions (with SPI_SCHED_FIXED_PRIO_EN defined: always 0).
- V4: req0, op 06, nbytes 0 -> 8 SPICLK rises, done[0] at cycle 17, rdata = 0; then nbytes 7 -> treated as 4 bytes.
- V5: reset asserted at cycle 30 of a V2 transaction -> chip_select = 1, SPICLK = 0, gnt = 0 within that cycle; no done; next req0 runs normally.
- V6: req0 dropped after 1 cycle while req1 transaction is busy -> no transaction for requester 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state encoding, flash opcodes and byte-count helper for the SPI command scheduler.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    OPCODE,
    ADDR,
    DATA,
    GAP
  } state_t;

  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  localparam int CNT_W    = 7;
  localparam int OP_CYC   = 16;
  localparam int ADDR_CYC = 48;

  // Byte counts above four collapse onto four.
  function automatic logic [2:0] eff_count(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/spi_cmd_scheduler_if.sv
// Requester-side bus of the SPI command scheduler: two requesters with packed per-requester fields.
interface spi_cmd_scheduler_if;
  logic [1:0]  req;
  logic [15:0] op;
  logic [47:0] addr;
  logic [1:0]  has_addr;
  logic [5:0]  nbytes;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        busy;

  modport master (output req, op, addr, has_addr, nbytes,
                  input  gnt, done, rdata, busy);
  modport slave  (input  req, op, addr, has_addr, nbytes,
                  output gnt, done, rdata, busy);
endinterface

// File: rtl/spi_rr_arbiter.sv
// Two-way arbiter; round-robin by default, fixed priority to requester 0 when
// SPI_SCHED_FIXED_PRIO_EN is defined.
module spi_rr_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

`ifdef SPI_SCHED_FIXED_PRIO_EN
  always_comb begin
    gnt = 2'b00;
    if (enable) gnt = req[0] ? 2'b01 : {req[1], 1'b0};
  end
`else
  logic ptr;  // 1 = requester 1 wins the next tie

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)     ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
`endif

endmodule

// File: rtl/spi_cmd_scheduler.sv
// SPI mode-0 flash command sequencer: opcode, optional 24-bit address, up to 4 read bytes.
// Arbitration mode selected by SPI_SCHED_FIXED_PRIO_EN (see spi_rr_arbiter).
module spi_cmd_scheduler
  import spi_pkg::*;
#(
  parameter int CS_GAP = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  spi_cmd_scheduler_if.slave   bus,
  output logic                 SPICLK,
  output logic                 SPIMOSI,
  input  logic                 SPIMISO,
  output logic                 chip_select
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   data_len;
  logic [1:0]         gnt_r, done_r, arb_gnt;
  logic [31:0]        rdata_r, tx, rx;
  logic               busy_r, sclk, cs_n, ha;
  logic [2:0]         nbyte;

  logic               sel;
  logic [7:0]         op_sel;
  logic [23:0]        addr_sel;
  logic               ha_sel;
  logic [2:0]         nb_sel;

  spi_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (bus.req),
    .enable (state == IDLE),
    .gnt    (arb_gnt)
  );

  assign sel      = arb_gnt[1];
  assign op_sel   = sel ? bus.op[15:8]    : bus.op[7:0];
  assign addr_sel = sel ? bus.addr[47:24] : bus.addr[23:0];
  assign ha_sel   = sel ? bus.has_addr[1] : bus.has_addr[0];
  assign nb_sel   = sel ? bus.nbytes[5:3] : bus.nbytes[2:0];
  assign data_len = {nbyte, 4'h0} - CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      rdata_r <= '0;
      busy_r  <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
      tx      <= '0;
      rx      <= '0;
      ha      <= 1'b0;
      nbyte   <= '0;
    end else begin
      done_r <= '0;
      case (state)
        IDLE: if (|arb_gnt) begin
          state  <= CS_SETUP;
          gnt_r  <= arb_gnt;
          busy_r <= 1'b1;
          cs_n   <= 1'b0;
          ha     <= ha_sel;
          nbyte  <= eff_count(nb_sel);
          tx     <= {op_sel, ha_sel ? addr_sel : 24'h0};
          rx     <= '0;
        end
        CS_SETUP: begin
          state <= OPCODE;
          cnt   <= CNT_W'(OP_CYC - 1);
          sclk  <= 1'b1;
        end
        OPCODE, ADDR, DATA: begin
          sclk <= ~sclk;
          // MOSI advances on the falling SPICLK; zeros shift in behind the command.
          if (sclk) tx <= {tx[30:0], 1'b0};
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            if (state == DATA && !sclk) rx <= {rx[30:0], SPIMISO};
          end else if (state == OPCODE && ha) begin
            state <= ADDR;
            cnt   <= CNT_W'(ADDR_CYC - 1);
          end else if (state != DATA && nbyte != 3'd0) begin
            state <= DATA;
            cnt   <= data_len;
            rx    <= {rx[30:0], SPIMISO};
          end else begin
            state   <= GAP;
            cnt     <= CNT_W'(CS_GAP - 1);
            sclk    <= 1'b0;
            cs_n    <= 1'b1;
            gnt_r   <= '0;
            done_r  <= gnt_r;
            rdata_r <= rx;
          end
        end
        GAP: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else begin
            state  <= IDLE;
            busy_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.done    = done_r;
  assign bus.rdata   = rdata_r;
  assign bus.busy    = busy_r;
  assign SPICLK      = sclk;
  assign SPIMOSI     = tx[31];
  assign chip_select = cs_n;

endmodule

// File: tb/tb_spi_cmd_scheduler.sv
// Bench for spi_cmd_scheduler: vector table, directed multi-cycle sequences and random
// transactions against a flash-slave model and spec-level expectation functions.
module tb_spi_cmd_scheduler;
  import spi_pkg::*;

  localparam int CS_GAP = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic SPICLK, SPIMOSI, chip_select;
  logic SPIMISO = 1'b0;

  spi_cmd_scheduler_if bus();

  spi_cmd_scheduler #(.CS_GAP(CS_GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .SPICLK      (SPICLK),
    .SPIMOSI     (SPIMOSI),
    .SPIMISO     (SPIMISO),
    .chip_select (chip_select)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Flash slave: counts SPICLK rises, captures command bits, returns resp MSB first after the command.
  logic [31:0] resp = '0;
  int          cmd_bits = 8;
  int          rises = 0;
  logic [31:0] mosi_cap = '0;
  logic        prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(posedge clk) begin
    #2;
    if (prev_cs && !chip_select) begin
      rises    = 0;
      mosi_cap = '0;
    end
    if (!prev_sclk && SPICLK) begin
      if (rises < cmd_bits) mosi_cap = {mosi_cap[30:0], SPIMOSI};
      rises++;
    end
    if (prev_sclk && !SPICLK)
      SPIMISO = (rises >= cmd_bits && rises - cmd_bits < 32) ? resp[31 - (rises - cmd_bits)] : 1'b0;
    prev_sclk = SPICLK;
    prev_cs   = chip_select;
  end

  // Expectations derived from the transaction rules.
  function automatic int m_cnt(input logic [2:0] nb);
    return (nb > 3'd4) ? 4 : int'(nb);
  endfunction
  function automatic int m_lat(input logic h, input logic [2:0] nb);
    return 1 + 16 + 48 * int'(h) + 16 * m_cnt(nb);
  endfunction
  function automatic logic [31:0] m_rdata(input logic [31:0] rs, input logic [2:0] nb);
    int c;
    c = m_cnt(nb);
    return (c == 0) ? 32'h0 : rs >> (8 * (4 - c));
  endfunction
  function automatic int m_rises(input logic h, input logic [2:0] nb);
    return 8 + 24 * int'(h) + 8 * m_cnt(nb);
  endfunction

  task automatic wait_gnt(output bit got);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.gnt != 2'b00) got = 1;
    end
  endtask

  task automatic do_txn(input string tag, input int k, input logic [7:0] o, input logic [23:0] a,
                        input logic h, input logic [2:0] nb, input logic [31:0] rs,
                        input int exp_lat, input logic [31:0] exp_rd, input int exp_rises);
    bit got;
    int lat;
    cmd_bits = h ? 32 : 8;
    resp     = rs;
    @(negedge clk);
    bus.op[8*k +: 8]     = o;
    bus.addr[24*k +: 24] = a;
    bus.has_addr[k]      = h;
    bus.nbytes[3*k +: 3] = nb;
    bus.req[k]           = 1'b1;
    wait_gnt(got);
    chk({tag, "_gnt"}, {30'h0, bus.gnt}, 32'(2'b01 << k));
    chk({tag, "_cs_low"}, {31'h0, chip_select}, 32'h0);
    bus.req[k] = 1'b0;
    // Fields must already be latched; disturb them.
    bus.op[8*k +: 8]     = ~o;
    bus.addr[24*k +: 24] = ~a;
    bus.has_addr[k]      = ~h;
    bus.nbytes[3*k +: 3] = 3'($urandom);
    lat = 0;
    got = 0;
    for (int i = 1; i <= 300 && !got; i++) begin
      @(posedge clk); #1;
      if (bus.done != 2'b00) begin got = 1; lat = i; end
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_done"}, {30'h0, bus.done}, 32'(2'b01 << k));
    chk({tag, "_rdata"}, bus.rdata, exp_rd);
    chk({tag, "_rises"}, rises, exp_rises);
    chk({tag, "_mosi"}, mosi_cap, h ? {o, a} : {24'h0, o});
    chk({tag, "_cs_end"}, {31'h0, chip_select}, 32'h1);
    chk({tag, "_gnt_end"}, {30'h0, bus.gnt}, 32'h0);
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {30'h0, bus.done}, 32'h0);
    chk({tag, "_rdata_hold"}, bus.rdata, exp_rd);
  endtask

  task automatic pulse_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
  endtask

  typedef struct {
    int          k;
    logic [7:0]  o;
    logic [23:0] a;
    logic        h;
    logic [2:0]  nb;
    logic [31:0] rs;
    int          lat;
    logic [31:0] rd;
    int          rises;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit   got;
    int   g, hits, bad;
    bit   seen1;
    logic [1:0] exp_g;

    vt[0] = '{0, OP_RDID, 24'h000000, 1'b0, 3'd3, 32'hEF401877,  65, 32'h00EF4018, 32};
    vt[1] = '{1, OP_READ, 24'h012345, 1'b1, 3'd4, 32'hAABBCCDD, 129, 32'hAABBCCDD, 64};
    vt[2] = '{0, OP_WREN, 24'h000000, 1'b0, 3'd0, 32'h12345678,  17, 32'h00000000,  8};
    vt[3] = '{0, OP_WREN, 24'h000000, 1'b0, 3'd7, 32'h11223344,  81, 32'h11223344, 40};
    vt[4] = '{1, OP_RDSR, 24'hABCDEF, 1'b1, 3'd1, 32'h5A123456,  81, 32'h0000005A, 40};

    bus.req = '0; bus.op = '0; bus.addr = '0; bus.has_addr = '0; bus.nbytes = '0;

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt",   {30'h0, bus.gnt},  32'h0);
    chk("rst_done",  {30'h0, bus.done}, 32'h0);
    chk("rst_rdata", bus.rdata,         32'h0);
    chk("rst_busy",  {31'h0, bus.busy}, 32'h0);
    chk("rst_sclk",  {31'h0, SPICLK},   32'h0);
    chk("rst_mosi",  {31'h0, SPIMOSI},  32'h0);
    chk("rst_cs",    {31'h0, chip_select}, 32'h1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("post_rst_cs",   {31'h0, chip_select}, 32'h1);

    // Table: V1, V2, V4 (count 0 and clamp), address + single byte.
    for (int i = 0; i < 5; i++)
      do_txn($sformatf("vec%0d", i), vt[i].k, vt[i].o, vt[i].a, vt[i].h, vt[i].nb, vt[i].rs,
             vt[i].lat, vt[i].rd, vt[i].rises);

    // V5: reset at cycle 30 of a READ transaction.
    cmd_bits = 32; resp = 32'hAABBCCDD;
    @(negedge clk);
    bus.op[15:8] = OP_READ; bus.addr[47:24] = 24'h012345; bus.has_addr[1] = 1'b1;
    bus.nbytes[5:3] = 3'd4; bus.req[1] = 1'b1;
    wait_gnt(got);
    chk("v5_gnt", {30'h0, bus.gnt}, 32'h2);
    bus.req[1] = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("v5_cs",   {31'h0, chip_select}, 32'h1);
    chk("v5_sclk", {31'h0, SPICLK},      32'h0);
    chk("v5_gnt0", {30'h0, bus.gnt},     32'h0);
    chk("v5_busy", {31'h0, bus.busy},    32'h0);
    @(negedge clk); @(negedge clk); reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (bus.done != 2'b00 || bus.gnt != 2'b00) hits++;
    end
    chk("v5_no_resume", hits, 0);
    do_txn("v5_next", 0, OP_RDID, 24'h0, 1'b0, 3'd2, 32'hC2201700, 49, 32'h0000C220, 24);

    // V3: both requesting after reset; round-robin 0,1,0 and chip_select gap.
    pulse_reset();
    cmd_bits = 8; resp = 32'h3C000000;
    @(negedge clk);
    bus.op = {OP_RDSR, OP_RDSR}; bus.has_addr = 2'b00; bus.nbytes = {3'd1, 3'd1}; bus.req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      g = 1;
      got = 0;
      for (int i = 0; i < 40 && !got; i++) begin
        @(posedge clk); #1;
        if (bus.gnt != 2'b00) got = 1;
        else if (chip_select) g++;
      end
      exp_g = (t == 1) ? 2'b10 : 2'b01;
      chk($sformatf("v3_gnt%0d", t), {30'h0, bus.gnt}, {30'h0, exp_g});
      if (t > 0) chk($sformatf("v3_gap%0d", t), {31'h0, g >= CS_GAP}, 32'h1);
      if (t == 2) bus.req = 2'b00;
      got = 0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(posedge clk); #1;
        if (bus.done != 2'b00) got = 1;
      end
      chk($sformatf("v3_done%0d", t), {30'h0, bus.done}, {30'h0, exp_g});
      chk($sformatf("v3_rdata%0d", t), bus.rdata, 32'h0000003C);
    end

    // V6: requester 0 pulses for one cycle while requester 1 is busy.
    cmd_bits = 32; resp = 32'h01020304;
    @(negedge clk);
    bus.op[15:8] = OP_READ; bus.addr[47:24] = 24'h000100; bus.has_addr[1] = 1'b1;
    bus.nbytes[5:3] = 3'd4; bus.req[1] = 1'b1;
    wait_gnt(got);
    chk("v6_gnt1", {30'h0, bus.gnt}, 32'h2);
    bus.req[1] = 1'b0;
    repeat (5) @(negedge clk);
    bus.req[0] = 1'b1;
    @(negedge clk);
    bus.req[0] = 1'b0;
    seen1 = 0; bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (bus.done[1]) seen1 = 1;
      if (bus.gnt[0] || bus.done[0]) bad++;
    end
    chk("v6_done1", {31'h0, seen1}, 32'h1);
    chk("v6_no_req0", bad, 0);

    // Random single-requester transactions.
    for (int n = 0; n < 12; n++) begin
      int          k;
      logic [7:0]  o;
      logic [23:0] a;
      logic        h;
      logic [2:0]  nb;
      logic [31:0] rs;
      k  = int'($urandom_range(0, 1));
      o  = 8'($urandom);
      a  = 24'($urandom);
      h  = 1'($urandom_range(0, 1));
      nb = 3'($urandom_range(0, 7));
      rs = $urandom;
      do_txn($sformatf("rnd%0d", n), k, o, a, h, nb, rs, m_lat(h, nb), m_rdata(rs, nb), m_rises(h, nb));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
